control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state control sequencer for an 8-bit accumulator CPU.
// Optional CTRL_SKIP_IDLE_EN returns to T0 right after an instruction's last active step.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        cf,
    input  logic        zf,
    output logic [14:0] control_signals,
    output logic [2:0]  t_state,
    output logic        halted
);

    localparam logic [2:0] S_T0   = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam int B_CP = 14, B_EP = 13, B_LP = 12, B_NLMA = 11, B_NLMD = 10;
    localparam int B_NCE = 9, B_NLR = 8, B_NLI = 7, B_NEI = 6, B_NLA = 5;
    localparam int B_EA = 4, B_SUB = 3, B_EU = 2, B_NLB = 1, B_NLO = 0;

    localparam logic [14:0] IDLE_WORD = 15'h0FE3;

    logic [2:0]  state_q, state_d;
    logic [2:0]  last_step;
    logic [14:0] word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Index of the final active step of the current instruction.
    always_comb begin
        last_step = S_T5;
`ifdef CTRL_SKIP_IDLE_EN
        case (opcode)
            4'h1:                      last_step = S_T4;
            4'h2, 4'h3, 4'h4:          last_step = S_T5;
            4'h5, 4'h6, 4'h7, 4'h8,
            4'hE:                      last_step = S_T3;
            4'hF:                      last_step = S_T5;
            default:                   last_step = S_T2;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: state_d = S_HALT;
            S_T3: begin
                if (opcode == 4'hF) begin
                    state_d = S_HALT;
                end else if (last_step == S_T3) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T0, S_T1, S_T2, S_T4, S_T5: begin
                if (state_q == last_step || state_q == S_T5) begin
                    state_d = S_T0;
                end else begin
                    state_d = state_q + 3'd1;
                end
            end
            default: state_d = S_T0;
        endcase
    end

    always_comb begin
        word = IDLE_WORD;
        case (state_q)
            S_T0: begin
                word[B_EP]   = 1'b1;
                word[B_NLMA] = 1'b0;
            end
            S_T1: word[B_CP] = 1'b1;
            S_T2: begin
                word[B_NCE] = 1'b0;
                word[B_NLI] = 1'b0;
            end
            S_T3: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        word[B_NEI]  = 1'b0;
                        word[B_NLMA] = 1'b0;
                    end
                    4'h5: begin
                        word[B_NEI] = 1'b0;
                        word[B_NLA] = 1'b0;
                    end
                    4'h6, 4'h7, 4'h8: begin
                        // Conditional jumps fall back to an idle step when not taken.
                        if (opcode == 4'h6 || (opcode == 4'h7 && cf) || (opcode == 4'h8 && zf)) begin
                            word[B_NEI] = 1'b0;
                            word[B_LP]  = 1'b1;
                        end
                    end
                    4'hE: begin
                        word[B_EA]  = 1'b1;
                        word[B_NLO] = 1'b0;
                    end
                    default: word = IDLE_WORD;
                endcase
            end
            S_T4: begin
                case (opcode)
                    4'h1: begin
                        word[B_NCE] = 1'b0;
                        word[B_NLA] = 1'b0;
                    end
                    4'h2, 4'h3: begin
                        word[B_NCE] = 1'b0;
                        word[B_NLB] = 1'b0;
                        word[B_SUB] = (opcode == 4'h3);
                    end
                    4'h4: begin
                        word[B_EA]   = 1'b1;
                        word[B_NLMD] = 1'b0;
                    end
                    default: word = IDLE_WORD;
                endcase
            end
            S_T5: begin
                case (opcode)
                    4'h2, 4'h3: begin
                        word[B_EU]  = 1'b1;
                        word[B_NLA] = 1'b0;
                        word[B_SUB] = (opcode == 4'h3);
                    end
                    4'h4: word[B_NLR] = 1'b0;
                    default: word = IDLE_WORD;
                endcase
            end
            default: word = IDLE_WORD;
        endcase
    end

    assign control_signals = rst ? IDLE_WORD : word;
    assign t_state         = (state_q == S_HALT) ? S_T0 : state_q;
    assign halted          = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer.
module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic [14:0] control_signals;
    logic [2:0]  t_state;
    logic        halted;

    int n_cmp;
    int n_bad;

    localparam logic [14:0] IDLE = 15'h0FE3;
    localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LP = 15'h1000, NLMA = 15'h0800;
    localparam logic [14:0] NLMD = 15'h0400, NCE = 15'h0200, NLR = 15'h0100, NLI = 15'h0080;
    localparam logic [14:0] NEI = 15'h0040, NLA = 15'h0020, EA = 15'h0010, SUB = 15'h0008;
    localparam logic [14:0] EU = 15'h0004, NLB = 15'h0002, NLO = 15'h0001;

    // Each step is the idle word with the listed controls toggled to their active level.
    logic [14:0] fetch_tgl [3];
    logic [14:0] exec_tgl  [16][3];
    int          len_tab   [16];

    control_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .cf              (cf),
        .zf              (zf),
        .control_signals (control_signals),
        .t_state         (t_state),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] expected_word(int step, int op, logic c, logic z);
        logic [14:0] t;
        if (step < 3) begin
            t = fetch_tgl[step];
        end else begin
            t = exec_tgl[op][step - 3];
            if ((op == 7 && !c) || (op == 8 && !z)) t = '0;
        end
        return IDLE ^ t;
    endfunction

    task automatic check_step(input int s, input int op, input logic c, input logic z);
        int drivers;
        #1;
        check($sformatf("t_state op%0h s%0d", op, s), t_state, s);
        check($sformatf("word op%0h s%0d c%0d z%0d", op, s, c, z), control_signals,
              expected_word(s, op, c, z));
        check($sformatf("halted op%0h s%0d", op, s), halted, 0);
        drivers = int'(control_signals[13]) + int'(!control_signals[9]) + int'(!control_signals[6])
                + int'(control_signals[4]) + int'(control_signals[2]);
        check($sformatf("bus drivers op%0h s%0d", op, s), drivers <= 1, 1);
        check($sformatf("cp_lp op%0h s%0d", op, s), control_signals[14] & control_signals[12], 0);
    endtask

    // Entered just after a negedge with the DUT in T0; returns the same way.
    task automatic run_instr(input int op, input logic c, input logic z);
        opcode = op[3:0];
        cf = c;
        zf = z;
        if (op == 15) begin
            for (int s = 0; s < 4; s++) begin
                check_step(s, op, c, z);
                @(negedge clk);
            end
            for (int i = 0; i < 20; i++) begin
                #1;
                check("halt halted", halted, 1);
                check("halt t_state", t_state, 0);
                check("halt word", control_signals, IDLE);
                @(negedge clk);
            end
            rst = 1'b1;
            #1;
            check("halt rst halted", halted, 0);
            check("halt rst t_state", t_state, 0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int s = 0; s < len_tab[op]; s++) begin
                check_step(s, op, c, z);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int t0;
        int seq_len;
        n_cmp = 0;
        n_bad = 0;

        fetch_tgl[0] = EP | NLMA;
        fetch_tgl[1] = CP;
        fetch_tgl[2] = NCE | NLI;
        for (int i = 0; i < 16; i++) begin
            exec_tgl[i][0] = '0;
            exec_tgl[i][1] = '0;
            exec_tgl[i][2] = '0;
        end
        exec_tgl[1]  = '{NEI | NLMA, NCE | NLA, 15'h0};
        exec_tgl[2]  = '{NEI | NLMA, NCE | NLB, EU | NLA};
        exec_tgl[3]  = '{NEI | NLMA, NCE | NLB | SUB, EU | NLA | SUB};
        exec_tgl[4]  = '{NEI | NLMA, EA | NLMD, NLR};
        exec_tgl[5]  = '{NEI | NLA, 15'h0, 15'h0};
        exec_tgl[6]  = '{NEI | LP, 15'h0, 15'h0};
        exec_tgl[7]  = '{NEI | LP, 15'h0, 15'h0};
        exec_tgl[8]  = '{NEI | LP, 15'h0, 15'h0};
        exec_tgl[14] = '{EA | NLO, 15'h0, 15'h0};

        for (int i = 0; i < 16; i++) len_tab[i] = 6;
`ifdef CTRL_SKIP_IDLE_EN
        for (int i = 0; i < 16; i++) len_tab[i] = 3;
        len_tab[1] = 5;
        len_tab[2] = 6;
        len_tab[3] = 6;
        len_tab[4] = 6;
        len_tab[5] = 4;
        len_tab[6] = 4;
        len_tab[7] = 4;
        len_tab[8] = 4;
        len_tab[14] = 4;
`endif

        rst = 1'b1;
        opcode = 4'h0;
        cf = 1'b0;
        zf = 1'b0;
        #2;
        check("reset word", control_signals, IDLE);
        check("reset t_state", t_state, 0);
        check("reset halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;

        // ADD interrupted in T4 by an asynchronous reset.
        opcode = 4'h2;
        for (int s = 0; s < 5; s++) begin
            check_step(s, 2, 1'b0, 1'b0);
            if (s < 4) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst word", control_signals, IDLE);
        check("midrst t_state", t_state, 0);
        check("midrst halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post rst fetch", control_signals, IDLE ^ (EP | NLMA));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Every opcode under every flag combination, HLT included.
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 4; f++) begin
                run_instr(op, f[0], f[1]);
            end
        end

        // LDI, OUT, NOP timed from T0 back to T0.
        t0 = $time;
        run_instr(5, 1'b0, 1'b0);
        run_instr(14, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b0);
`ifdef CTRL_SKIP_IDLE_EN
        seq_len = 11;
`else
        seq_len = 18;
`endif
        #1;
        check("seq clocks", ($time - 1 - t0) / 10, seq_len);
        check("seq end t_state", t_state, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, 15), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
